// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared single-cycle ALU.
// The ALU sees the shifted multiplicand on a and the running accumulator on b.
// Each cycle it either adds them or passes the accumulator through, depending
// on the current low multiplier bit.
module alu_mul_sequencer #(
   parameter int unsigned W     = 64,
   parameter int unsigned CNT_W = $clog2(W)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] product,
   output logic         resp_zero,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   input  logic [W-1:0] alu_result
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [3:0] AluAdd   = 4'b0010;
   localparam logic [3:0] AluPassB = 4'b0111;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(W - 1);

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: load operands on accept, one shift-add step per RUN cycle.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d  = StRun;
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         StRun: begin
            acc_d    = alu_result;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // Last iteration still updates acc; counter just stops.
            if (cnt_q == CntLast) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Handshake and ALU drive; ALU is parked on pass-b of the accumulator outside RUN.
   always_comb begin
      req_ready  = (state_q == StIdle);
      resp_valid = (state_q == StDone);
      product    = acc_q;
      resp_zero  = (acc_q == '0);
      alu_b      = acc_q;
      alu_a      = '0;
      alu_ctrl   = AluPassB;
      if (state_q == StRun) begin
         alu_a    = mcand_q;
         alu_ctrl = mplier_q[0] ? AluAdd : AluPassB;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
